// File: rtl/rgb_led_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rgb_led_scheduler                                          |
// | Description : Priority scheduler that grants one of N_REQ status         |
// |               requesters the RGB LEDs for a minimum hold time, with      |
// |               preemption, blink modes, global PWM dimming and an idle    |
// |               green heartbeat.                                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module rgb_led_scheduler #(
   parameter int          LED_NUM     = 1,
   parameter int          N_REQ       = 4,
   parameter int unsigned HOLD_CYCLES = 2**24,
   parameter int          SLOW_BIT    = 26,
   parameter int          FAST_BIT    = 23
) (
   input  logic                 extra_clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   input  logic [3*N_REQ-1:0]   req_color,
   input  logic [2*N_REQ-1:0]   req_mode,
   input  logic [7:0]           brightness,
   output logic [N_REQ-1:0]     owner,
   output logic                 active,
   output logic [LED_NUM-1:0]   led_r,
   output logic [LED_NUM-1:0]   led_g,
   output logic [LED_NUM-1:0]   led_b
);

   localparam logic [0:0]  c_ST_IDLE     = 1'b0;
   localparam logic [0:0]  c_ST_HOLD     = 1'b1;
   localparam logic [31:0] c_HOLD_RELOAD = 32'(HOLD_CYCLES - 32'd1);

   logic [0:0]         state_q, state_d;
   logic [31:0]        cnt_q, cnt_d;
   logic [31:0]        hold_q, hold_d;
   logic [2:0]         color_q, color_d;
   logic [1:0]         mode_q, mode_d;
   logic [N_REQ-1:0]   owner_q, owner_d;
   logic               active_q, active_d;
   logic [LED_NUM-1:0] led_r_q, led_r_d;
   logic [LED_NUM-1:0] led_g_q, led_g_d;
   logic [LED_NUM-1:0] led_b_q, led_b_d;

   logic [N_REQ-1:0]   w_grant_oh;
   logic [N_REQ-1:0]   w_higher_req;
   logic [2:0]         w_sel_color;
   logic [1:0]         w_sel_mode;
   logic               w_pwm_on;
   logic               w_mode_on;
   logic [2:0]         w_rgb;

   // Lowest asserted request wins; bits below the one-hot owner are the strictly higher priorities
   assign w_grant_oh   = req & (~req + 1'b1);
   assign w_higher_req = req & (owner_q - 1'b1);

   // State register: every flop, with reset clearing any grant in progress
   always_ff @(posedge extra_clk) begin
      if (rst) begin
         state_q  <= c_ST_IDLE;
         cnt_q    <= '0;
         hold_q   <= '0;
         color_q  <= '0;
         mode_q   <= '0;
         owner_q  <= '0;
         active_q <= 1'b0;
         led_r_q  <= '0;
         led_g_q  <= '0;
         led_b_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hold_q   <= hold_d;
         color_q  <= color_d;
         mode_q   <= mode_d;
         owner_q  <= owner_d;
         active_q <= active_d;
         led_r_q  <= led_r_d;
         led_g_q  <= led_g_d;
         led_b_q  <= led_b_d;
      end
   end

   // Next state: arbitration, preemption, hold countdown and color/mode latching
   always_comb begin
      cnt_d       = cnt_q + 32'd1;
      state_d     = state_q;
      hold_d      = hold_q;
      owner_d     = owner_q;
      color_d     = color_q;
      mode_d      = mode_q;
      w_sel_color = '0;
      w_sel_mode  = '0;

      case (state_q)
         c_ST_IDLE: begin
            if (|req) begin
               state_d = c_ST_HOLD;
               owner_d = w_grant_oh;
               hold_d  = c_HOLD_RELOAD;
            end
         end
         c_ST_HOLD: begin
            if (hold_q == 32'd0) begin
               if (|req) begin
                  owner_d = w_grant_oh;
                  hold_d  = c_HOLD_RELOAD;
               end else begin
                  state_d = c_ST_IDLE;
                  owner_d = '0;
               end
            end else if (|w_higher_req) begin
               owner_d = w_grant_oh;
               hold_d  = c_HOLD_RELOAD;
            end else begin
               hold_d = hold_q - 32'd1;
            end
         end
         default: begin
            state_d = c_ST_IDLE;
            owner_d = '0;
            hold_d  = '0;
         end
      endcase

      for (int i = 0; i < N_REQ; i++) begin
         if (owner_d[i]) begin
            w_sel_color = req_color[3*i +: 3];
            w_sel_mode  = req_mode[2*i +: 2];
         end
      end

      // A dropped owner keeps its last latched look; a fresh grant always has its req high
      if (state_d == c_ST_IDLE) begin
         color_d = '0;
         mode_d  = '0;
      end else if (|(req & owner_d)) begin
         color_d = w_sel_color;
         mode_d  = w_sel_mode;
      end
   end

   // Output values, built from next-state values so the registered LEDs match the live counter
   always_comb begin
      w_pwm_on = (cnt_d[7:0] < brightness);
      case (mode_d)
         2'b00:   w_mode_on = 1'b0;
         2'b01:   w_mode_on = 1'b1;
         2'b10:   w_mode_on = cnt_d[SLOW_BIT];
         default: w_mode_on = cnt_d[FAST_BIT];
      endcase
      if (state_d == c_ST_HOLD) begin
         w_rgb = color_d & {3{w_mode_on & w_pwm_on}};
      end else begin
         w_rgb = {1'b0, cnt_d[SLOW_BIT] & w_pwm_on, 1'b0};
      end
      active_d = (state_d == c_ST_HOLD);
      led_r_d  = {LED_NUM{w_rgb[2]}};
      led_g_d  = {LED_NUM{w_rgb[1]}};
      led_b_d  = {LED_NUM{w_rgb[0]}};
   end

   assign owner  = owner_q;
   assign active = active_q;
   assign led_r  = led_r_q;
   assign led_g  = led_g_q;
   assign led_b  = led_b_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_led_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_rgb_led_scheduler                                       |
// | Description : Scoreboard bench for rgb_led_scheduler. Directed vectors   |
// |               push the expected owner/active/LED values for each cycle;  |
// |               an independent monitor pops and compares every cycle.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_rgb_led_scheduler;

   localparam int LN = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    req;
   logic [11:0]   req_color;
   logic [7:0]    req_mode;
   logic [7:0]    brightness;
   logic [3:0]    owner;
   logic          active;
   logic [LN-1:0] led_r;
   logic [LN-1:0] led_g;
   logic [LN-1:0] led_b;

   typedef struct packed {
      logic [3:0] owner;
      logic       active;
      logic [2:0] rgb;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   // staged stimulus, applied on the next falling edge by tick()
   logic        s_rst;
   logic [3:0]  s_req;
   logic [11:0] s_col;
   logic [7:0]  s_mode;
   logic [7:0]  s_br;
   logic [31:0] m_cnt = '0;

   always #5 clk = ~clk;

   rgb_led_scheduler #(
      .LED_NUM     (LN),
      .N_REQ       (4),
      .HOLD_CYCLES (16),
      .SLOW_BIT    (5),
      .FAST_BIT    (3)
   ) dut (
      .extra_clk  (clk),
      .rst        (rst),
      .req        (req),
      .req_color  (req_color),
      .req_mode   (req_mode),
      .brightness (brightness),
      .owner      (owner),
      .active     (active),
      .led_r      (led_r),
      .led_g      (led_g),
      .led_b      (led_b)
   );

   // Drive one cycle of stimulus and queue the outputs expected after the next edge
   task automatic tick(input logic [3:0] eo, input logic [2:0] ec, input logic [1:0] em,
                       input string nm);
      exp_t e;
      logic pwm;
      logic mon;
      @(negedge clk);
      rst        = s_rst;
      req        = s_req;
      req_color  = s_col;
      req_mode   = s_mode;
      brightness = s_br;
      if (s_rst) m_cnt = '0;
      else       m_cnt = m_cnt + 32'd1;
      pwm = (m_cnt[7:0] < s_br);
      case (em)
         2'b00:   mon = 1'b0;
         2'b01:   mon = 1'b1;
         2'b10:   mon = m_cnt[5];
         default: mon = m_cnt[3];
      endcase
      if (s_rst) begin
         e = '0;
      end else if (eo == 4'b0000) begin
         e.owner  = 4'b0000;
         e.active = 1'b0;
         e.rgb    = {1'b0, m_cnt[5] & pwm, 1'b0};
      end else begin
         e.owner  = eo;
         e.active = 1'b1;
         e.rgb    = ec & {3{mon & pwm}};
      end
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic ticks(input int n, input logic [3:0] eo, input logic [2:0] ec,
                        input logic [1:0] em, input string nm);
      for (int k = 0; k < n; k++) tick(eo, ec, em, nm);
   endtask

   // Monitor: one expected entry per clock, sampled 1 time unit after the edge
   initial begin : monitor
      exp_t  e;
      string nm;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if (owner !== e.owner) begin
               n_bad++;
               $display("FAIL %s owner: got %b expected %b (t=%0t)", nm, owner, e.owner, $time);
            end
            n_cmp++;
            if (active !== e.active) begin
               n_bad++;
               $display("FAIL %s active: got %b expected %b (t=%0t)", nm, active, e.active, $time);
            end
            n_cmp++;
            if ({led_r, led_g, led_b} !== {{LN{e.rgb[2]}}, {LN{e.rgb[1]}}, {LN{e.rgb[0]}}}) begin
               n_bad++;
               $display("FAIL %s leds r/g/b: got %b/%b/%b expected %b/%b/%b (t=%0t)",
                        nm, led_r, led_g, led_b,
                        {LN{e.rgb[2]}}, {LN{e.rgb[1]}}, {LN{e.rgb[0]}}, $time);
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      s_rst  = 1'b1;
      s_req  = 4'b1111;
      s_col  = {3'b110, 3'b100, 3'b010, 3'b001};
      s_mode = {2'b11, 2'b01, 2'b10, 2'b01};
      s_br   = 8'd0;
      rst        = s_rst;
      req        = s_req;
      req_color  = s_col;
      req_mode   = s_mode;
      brightness = s_br;

      // reset holds everything at zero and ignores requests
      ticks(2, 4'b0000, 3'b000, 2'b00, "reset");

      // idle heartbeat, long enough to see cnt[5] toggle and the PWM cut off above 200
      s_rst = 1'b0; s_req = 4'b0000; s_br = 8'd200;
      ticks(230, 4'b0000, 3'b000, 2'b00, "idle_heartbeat");

      // single grant of requester 2 in solid red, spanning cnt[7:0]=255
      s_req = 4'b0100; s_br = 8'd255;
      ticks(32, 4'b0100, 3'b100, 2'b01, "single_grant");
      s_req = 4'b0000;
      ticks(1, 4'b0000, 3'b000, 2'b00, "grant_end_idle");

      // priority, then hold of the last latched look after the owner drops
      s_br = 8'd128;
      s_req = 4'b1010;
      ticks(3, 4'b0010, 3'b010, 2'b10, "prio_low_index");
      s_req = 4'b1000; s_col[5:3] = 3'b111; s_mode[3:2] = 2'b11;
      ticks(13, 4'b0010, 3'b010, 2'b10, "held_after_drop");
      ticks(4, 4'b1000, 3'b110, 2'b11, "next_owner");
      s_req = 4'b0000;
      ticks(12, 4'b1000, 3'b110, 2'b11, "owner3_held");
      ticks(2, 4'b0000, 3'b000, 2'b00, "idle_after_hold");

      // preemption by a higher priority only
      s_br = 8'd255;
      s_col = {3'b110, 3'b100, 3'b010, 3'b001};
      s_mode = {2'b11, 2'b01, 2'b10, 2'b01};
      s_req = 4'b0100;
      ticks(3, 4'b0100, 3'b100, 2'b01, "grant2");
      s_req = 4'b1100;
      ticks(7, 4'b0100, 3'b100, 2'b01, "low_prio_ignored");
      s_req = 4'b1101;
      ticks(5, 4'b0001, 3'b001, 2'b01, "preempt");
      s_req = 4'b0000;
      ticks(11, 4'b0001, 3'b001, 2'b01, "preempt_held");
      ticks(2, 4'b0000, 3'b000, 2'b00, "idle2");

      // blink modes, off mode and zero brightness, reloaded live from requester 0
      s_req = 4'b0001; s_col[2:0] = 3'b111;
      s_mode[1:0] = 2'b10;
      ticks(40, 4'b0001, 3'b111, 2'b10, "mode_slow");
      s_mode[1:0] = 2'b11;
      ticks(16, 4'b0001, 3'b111, 2'b11, "mode_fast");
      s_mode[1:0] = 2'b00;
      ticks(4, 4'b0001, 3'b111, 2'b00, "mode_off");
      s_mode[1:0] = 2'b01; s_br = 8'd0;
      ticks(4, 4'b0001, 3'b111, 2'b01, "dim_zero");

      // reset mid-hold, then a clean grant with a full 16-cycle window
      s_col = {3'b110, 3'b100, 3'b010, 3'b001};
      s_mode = {2'b11, 2'b01, 2'b10, 2'b01};
      s_br = 8'd255;
      s_rst = 1'b1; s_req = 4'b0100;
      ticks(1, 4'b0000, 3'b000, 2'b00, "reset_ignores_req");
      s_rst = 1'b0;
      ticks(6, 4'b0100, 3'b100, 2'b01, "post_reset_grant");
      s_rst = 1'b1;
      ticks(1, 4'b0000, 3'b000, 2'b00, "mid_hold_reset");
      s_rst = 1'b0;
      ticks(1, 4'b0100, 3'b100, 2'b01, "regrant_after_reset");
      s_req = 4'b0000;
      ticks(15, 4'b0100, 3'b100, 2'b01, "full_window");
      ticks(2, 4'b0000, 3'b000, 2'b00, "final_idle");

      @(posedge clk);
      #2;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
